wb_write_queue: RTL and testbench

- Write-back initiator for the 8x16-bit register file: the producing end of the reg_write / write_reg / write_data interface.
- Accepts register-write requests from two sources, the ALU result path and the load-data path, each with a valid/ready handshake.
- Arbitrates between the sources, buffers requests in a small in-order queue and retires one write per cycle into the register file.
- Provides bypass data for reads of registers that still have queued writes, so the decode stage never reads stale values.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fwd_match.sv | 29 ++
 rtl/wb_write_queue.sv | 130 +++++++++++++
 tb/tb_wb_write_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the write-back queue and its helpers.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] idx;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_LOAD = 1'b0,
        SRC_ALU  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over queue entries presented oldest-first (entry 0 oldest).
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [DEPTH-1:0]             occ_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] idx_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]            read_reg_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    // Later (younger) matches overwrite earlier ones, so the last hit wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_i[i] && (idx_i[i] == read_reg_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[i];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back initiator: arbitrates ALU/load write requests into an in-order queue,
// retires one register-file write per cycle and forwards queued data to decode reads.
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_stall,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [ADDR_W:0]   pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    wb_src_e           rr_prio_q, rr_prio_d;

    logic   full, empty;
    logic   alu_fire, ld_fire, enq, deq;
    entry_t enq_entry;

    logic [DEPTH-1:0]             ord_occ;
    logic [DEPTH-1:0][ADDR_W-1:0] ord_idx;
    logic [DEPTH-1:0][DATA_W-1:0] ord_data;

    // Handshake: a source transfers on a cycle where its valid and ready are both high.
    // Readies drop while full even if the head retires that cycle (no pass-through).
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        alu_ready = !full && (!ld_valid || (rr_prio_q == SRC_ALU));
        ld_ready  = !full && (!alu_valid || (rr_prio_q == SRC_LOAD));
        alu_fire  = alu_valid && alu_ready;
        ld_fire   = ld_valid && ld_ready;
        enq       = alu_fire || ld_fire;
        enq_entry = ld_fire ? '{idx: ld_reg, data: ld_data}
                            : '{idx: alu_reg, data: alu_data};
        reg_write  = !empty && !wb_stall;
        deq        = reg_write;
        write_reg  = mem_q[rd_ptr_q].idx;
        write_data = mem_q[rd_ptr_q].data;
        pending    = (ADDR_W+1)'(count_q);
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
        rr_prio_d = rr_prio_q;
        if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Priority only rotates when both sources compete and one is granted.
        if (alu_valid && ld_valid && enq) rr_prio_d = ld_fire ? SRC_ALU : SRC_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rr_prio_q <= SRC_LOAD;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rr_prio_q <= rr_prio_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= enq_entry;
    end

    // Present occupied entries in age order so the matcher can take the last hit.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_occ[i]  = (CNT_W'(i) < count_q);
            ord_idx[i]  = mem_q[rd_ptr_q + PTR_W'(i)].idx;
            ord_data[i] = mem_q[rd_ptr_q + PTR_W'(i)].data;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
        .occ_i      (ord_occ),
        .idx_i      (ord_idx),
        .data_i     (ord_data),
        .read_reg_i (read_reg1),
        .hit_o      (fwd_hit1),
        .data_o     (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
        .occ_i      (ord_occ),
        .idx_i      (ord_idx),
        .data_i     (ord_data),
        .read_reg_i (read_reg2),
        .hit_o      (fwd_hit2),
        .data_o     (fwd_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: vector table for arbitration/forwarding plus hand sequences.
module tb_wb_write_queue;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [2:0]  ld_reg;
    logic [15:0] ld_data;
    logic        wb_stall;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic [2:0]  read_reg1, read_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    wb_write_queue dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_reg     (ld_reg),
        .ld_data    (ld_data),
        .wb_stall   (wb_stall),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every retiring write must match the oldest accepted request.
    always @(negedge clk) begin
        if (!rst && reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected act=%h exp=none", {write_reg, write_data});
            end else begin
                if ({write_reg, write_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL retire act=%h exp=%h", {write_reg, write_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at a posedge; leaves time at the following negedge for checks.
    task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic lv, input logic [2:0] lr, input logic [15:0] ldv,
                         input logic st, input logic [2:0] r1, input logic [2:0] r2);
        #1;
        rst = 1'b0;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        ld_valid = lv;  ld_reg = lr;  ld_data = ldv;
        wb_stall = st;  read_reg1 = r1; read_reg2 = r2;
        @(negedge clk);
    endtask

    task automatic drive_idle(input logic st);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, st, 3'd0, 3'd0);
    endtask

    task automatic commit();
        if (ld_valid && ld_ready) exp_q.push_back({ld_reg, ld_data});
        else if (alu_valid && alu_ready) exp_q.push_back({alu_reg, alu_data});
        @(posedge clk);
    endtask

    task automatic reset_dut(input logic st);
        #1;
        rst = 1'b1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        wb_stall  = st;
        @(negedge clk);
        chk("reset_no_write", 32'(reg_write), 32'd0);
        @(posedge clk);
        @(posedge clk);
        exp_q.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive_idle(1'b0);
        while (pending != 4'd0 && n < 20) begin
            commit();
            drive_idle(1'b0);
            n++;
        end
        chk("drain_pending", 32'(pending), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        commit();
    endtask

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        lv;
        logic [2:0]  lr;
        logic [15:0] ld;
        logic        st;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic        e_ar;
        logic        e_lr;
        logic [3:0]  e_pend;
        logic        e_h1;
        logic [15:0] e_d1;
        logic        e_h2;
        logic [15:0] e_d2;
    } vec_t;

    vec_t vt[13];

    initial begin
        // Contested grants, single-source grants, forwarding, full-queue readies.
        vt[0]  = '{1'b1, 3'd2, 16'h5555, 1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd1, 3'd2,
                   1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 3'd2, 16'h5555, 1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd1, 3'd2,
                   1'b1, 1'b0, 4'd1, 1'b1, 16'hAAAA, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, 3'd2, 16'h5555, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd1, 3'd2,
                   1'b0, 1'b1, 4'd1, 1'b0, 16'h0000, 1'b1, 16'h5555};
        vt[3]  = '{1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd6,
                   1'b1, 1'b0, 4'd1, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vt[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0077, 1'b1, 3'd6, 3'd5,
                   1'b1, 1'b1, 4'd2, 1'b1, 16'h0066, 1'b1, 16'hBEEF};
        vt[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd0,
                   1'b1, 1'b1, 4'd3, 1'b1, 16'h0077, 1'b0, 16'h0000};
        vt[6]  = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd0, 16'h1111, 1'b1, 3'd7, 3'd0,
                   1'b1, 1'b0, 4'd3, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[7]  = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd0, 16'h1111, 1'b0, 3'd7, 3'd5,
                   1'b0, 1'b0, 4'd4, 1'b1, 16'h7777, 1'b1, 16'hBEEF};
        vt[8]  = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd0, 16'h1111, 1'b0, 3'd5, 3'd6,
                   1'b0, 1'b1, 4'd3, 1'b0, 16'h0000, 1'b1, 16'h0077};
        vt[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6,
                   1'b1, 1'b1, 4'd3, 1'b1, 16'h1111, 1'b1, 16'h0077};
        vt[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 3'd7,
                   1'b1, 1'b1, 4'd2, 1'b0, 16'h0000, 1'b1, 16'h7777};
        vt[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3,
                   1'b1, 1'b1, 4'd1, 1'b1, 16'h1111, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd7,
                   1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000};

        rst = 1'b1;
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 16'h0;
        ld_valid = 1'b0;  ld_reg = 3'd0;  ld_data = 16'h0;
        wb_stall = 1'b0;  read_reg1 = 3'd0; read_reg2 = 3'd0;
        @(posedge clk);

        // Reset state and single ALU write latency.
        reset_dut(1'b0);
        drive_idle(1'b0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_hits", 32'({fwd_hit1, fwd_hit2}), 32'd0);
        commit();
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_no_write_yet", 32'(reg_write), 32'd0);
        commit();
        drive_idle(1'b0);
        chk("t1_reg_write", 32'(reg_write), 32'd1);
        chk("t1_write_reg", 32'(write_reg), 32'd3);
        chk("t1_write_data", 32'(write_data), 32'h1234);
        chk("t1_pending1", 32'(pending), 32'd1);
        commit();
        drive_idle(1'b0);
        chk("t1_pending0", 32'(pending), 32'd0);
        chk("t1_idle_write", 32'(reg_write), 32'd0);
        commit();

        // Vector table.
        reset_dut(1'b0);
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].lv, vt[i].lr, vt[i].ld,
                  vt[i].st, vt[i].r1, vt[i].r2);
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vt[i].e_ar));
            chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vt[i].e_lr));
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vt[i].e_pend));
            chk($sformatf("v%0d_fwd1", i), {15'd0, fwd_hit1, fwd_data1}, {15'd0, vt[i].e_h1, vt[i].e_d1});
            chk($sformatf("v%0d_fwd2", i), {15'd0, fwd_hit2, fwd_data2}, {15'd0, vt[i].e_h2, vt[i].e_d2});
            commit();
        end
        drain();

        // Fill under stall, then release.
        reset_dut(1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'(k), 16'h0100 + 16'(k), 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
            chk($sformatf("t3_ready%0d", k), 32'(alu_ready), 32'd1);
            chk($sformatf("t3_pend%0d", k), 32'(pending), 32'(k));
            commit();
        end
        drive(1'b1, 3'd4, 16'h0104, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
        chk("t3_full_ready", 32'(alu_ready), 32'd0);
        chk("t3_full_pending", 32'(pending), 32'd4);
        commit();
        drive(1'b1, 3'd4, 16'h0104, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        chk("t3_full_deq_ready", 32'(alu_ready), 32'd0);
        chk("t3_full_deq_write", 32'(reg_write), 32'd1);
        commit();
        drive(1'b1, 3'd4, 16'h0104, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
        chk("t3_after_ready", 32'(alu_ready), 32'd1);
        chk("t3_after_pending", 32'(pending), 32'd3);
        commit();
        for (int k = 0; k < 3; k++) begin
            drive_idle(1'b0);
            chk($sformatf("t3_consec%0d", k), 32'(reg_write), 32'd1);
            commit();
        end
        drain();

        // Two writes to the same register: youngest forwarded.
        reset_dut(1'b1);
        drive(1'b1, 3'd3, 16'h0001, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
        commit();
        drive(1'b1, 3'd3, 16'h0002, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd4);
        chk("t4_new_not_visible", 32'({fwd_hit1, fwd_data1}), {15'd0, 1'b1, 16'h0001});
        commit();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd4);
        chk("t4_hit1", 32'(fwd_hit1), 32'd1);
        chk("t4_data1", 32'(fwd_data1), 32'h0002);
        chk("t4_hit2", 32'(fwd_hit2), 32'd0);
        chk("t4_data2", 32'(fwd_data2), 32'd0);
        commit();
        drain();

        // Reset mid-operation drops all queued writes.
        reset_dut(1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'(k + 1), 16'h0300 + 16'(k), 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0);
            commit();
        end
        reset_dut(1'b1);
        drive_idle(1'b1);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_reg_write", 32'(reg_write), 32'd0);
        commit();
        for (int k = 0; k < 5; k++) begin
            drive_idle(1'b0);
            chk($sformatf("t5_no_retire%0d", k), 32'(reg_write), 32'd0);
            commit();
        end

        // Steady stream across pointer wrap.
        reset_dut(1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 3'(k % 8), 16'h2000 + 16'($urandom_range(0, 255)) * 16'h10 + 16'(k),
                  1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0);
            chk($sformatf("t6_ready%0d", k), 32'(alu_ready), 32'd1);
            chk($sformatf("t6_pend%0d", k), 32'(pending), (k == 0) ? 32'd0 : 32'd1);
            commit();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
